// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 control block for the five-stage pipeline.
//
// Holds SR (12), Cause (13), EPC (14) and a constant PRId (15). It raises
// Req combinationally in the cycle that an enabled interrupt or a
// synchronous exception is seen in the M stage. On that clock edge it
// captures EPC, BD and ExcCode and sets SR.EXL.
//
// Ports:
//   clk, reset  clock; synchronous active-high reset
//   WE          mtc0 write enable (M stage)
//   Addr        CP0 register number for mtc0/mfc0
//   WData       mtc0 write data
//   RData       mfc0 read data, combinational, shows the pre-clock value
//   VPC         PC of the victim instruction
//   BDIn        victim sits in a branch delay slot
//   ExcCodeIn   synchronous exception code (0 = none)
//   HWInt       level-sensitive external interrupt lines
//   EXLClr      eret in M stage
//   EPCOut      current EPC register (eret target)
//   Req         flush pipeline and redirect fetch to HandlerPC
//   HandlerPC   constant exception entry address
//
// There is no handshake. Req is a single-cycle combinational request, and
// the downstream stages act on it in the same cycle.
module cp0_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [4:0]  Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req     = int_req | exc_req;

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

  always_comb begin
    RData = 32'd0;
    case (Addr)
      ADDR_SR:    RData = sr_val;
      ADDR_CAUSE: RData = cause_val;
      ADDR_EPC:   RData = epc_q;
      ADDR_PRID:  RData = PRID;
      default:    RData = 32'd0;
    endcase
  end

  assign EPCOut    = epc_q;
  assign HandlerPC = HANDLER_PC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // IP tracks the interrupt lines every cycle, whatever else happens.
    ip_d       = HWInt;

    if (Req) begin
      // Entry to the handler overrides mtc0 and eret in the same cycle.
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (WE) begin
        case (Addr)
          ADDR_SR: begin
            im_d  = WData[15:10];
            exl_d = WData[1];
            ie_d  = WData[0];
          end
          ADDR_EPC: epc_d = WData;
          default:  ;
        endcase
      end
      // eret is applied after any same-cycle mtc0 to SR, so EXL ends up clear.
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed bench for cp0_ctrl. The driver applies one cycle
// of inputs just after each rising edge and pushes the expected values.
// The monitor compares them at the following falling edge.
module tb_cp0_ctrl;

  localparam int SEL_REQ   = 0;
  localparam int SEL_RDATA = 1;
  localparam int SEL_EPC   = 2;
  localparam int SEL_HPC   = 3;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [4:0]  Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;
  logic [31:0] HandlerPC;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];

  int checks = 0;
  int errors = 0;

  cp0_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .WE        (WE),
    .Addr      (Addr),
    .WData     (WData),
    .RData     (RData),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req),
    .HandlerPC (HandlerPC)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: actual timeout required finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    WE        = 1'b0;
    EXLClr    = 1'b0;
    ExcCodeIn = 5'd0;
    BDIn      = 1'b0;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] val, input string name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic expect_rd(input logic [4:0] a, input logic [31:0] val, input string name);
    Addr = a;
    expect_val(SEL_RDATA, val, name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic int          sel  = sel_q.pop_front();
      automatic logic [31:0] expv = exp_q.pop_front();
      automatic string       nm   = name_q.pop_front();
      automatic logic [31:0] act;
      case (sel)
        SEL_REQ:   act = {31'd0, Req};
        SEL_RDATA: act = RData;
        SEL_EPC:   act = EPCOut;
        default:   act = HandlerPC;
      endcase
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s: actual %08h required %08h", nm, act, expv);
      end
    end
  end

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 5'd0; WData = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

    // reset values
    step(); expect_rd(5'd12, 32'h0, "rst_sr");
    step(); expect_rd(5'd13, 32'h0, "rst_cause");
    step(); expect_rd(5'd14, 32'h0, "rst_epc");
            expect_val(SEL_HPC, 32'h0000_4180, "handler_pc");
    step(); expect_rd(5'd15, 32'h2023_0007, "rst_prid");

    // mtc0 SR = FC01, then an interrupt on line 2
    step(); reset = 1'b0;
            WE = 1'b1; Addr = 5'd12; WData = 32'h0000_FC01;
            expect_val(SEL_REQ, 32'd0, "req_before_int");
    step(); HWInt = 6'b000100; VPC = 32'h0000_1000;
            expect_rd(5'd12, 32'h0000_FC01, "sr_written");
            expect_val(SEL_REQ, 32'd1, "int_req");
    step(); expect_val(SEL_REQ, 32'd0, "req_blocked_by_exl");
            expect_rd(5'd13, 32'h0000_1000, "int_cause");
            expect_val(SEL_EPC, 32'h0000_1000, "int_epc");
    step(); expect_rd(5'd12, 32'h0000_FC03, "sr_exl_set");

    // exception while EXL=1 is ignored
    step(); ExcCodeIn = 5'd4; VPC = 32'h0000_2000; BDIn = 1'b1;
            expect_val(SEL_REQ, 32'd0, "exc_under_exl");
    step(); expect_val(SEL_EPC, 32'h0000_1000, "epc_kept_under_exl");
            expect_rd(5'd13, 32'h0000_1000, "cause_kept_under_exl");

    // eret with a pending enabled interrupt
    step(); EXLClr = 1'b1;
            expect_val(SEL_REQ, 32'd0, "eret_cycle_req");
            expect_val(SEL_EPC, 32'h0000_1000, "eret_cycle_epc");
    step(); VPC = 32'h0000_2400;
            expect_val(SEL_REQ, 32'd1, "int_after_eret");
    step(); HWInt = 6'd0;
            expect_val(SEL_EPC, 32'h0000_2400, "epc_after_reint");

    // synchronous exception in a delay slot
    step(); EXLClr = 1'b1;
            expect_val(SEL_REQ, 32'd0, "eret2_req");
    step(); ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 1'b1;
            expect_val(SEL_REQ, 32'd1, "exc_req");
    step(); expect_rd(5'd13, 32'h8000_0030, "exc_cause");
            expect_val(SEL_EPC, 32'h0000_300C, "exc_epc_bd");

    // mtc0 to Cause is ignored
    step(); WE = 1'b1; Addr = 5'd13; WData = 32'h0000_0000;
    step(); expect_rd(5'd13, 32'h8000_0030, "cause_not_writable");

    // interrupt beats exception; same-cycle mtc0 EPC is discarded
    step(); EXLClr = 1'b1;
    step(); HWInt = 6'b000100; ExcCodeIn = 5'd10; VPC = 32'h0000_5000;
            WE = 1'b1; Addr = 5'd14; WData = 32'h1234_5678;
            expect_val(SEL_REQ, 32'd1, "int_and_exc_req");
    step(); HWInt = 6'd0;
            expect_rd(5'd13, 32'h0000_1000, "int_wins_cause");
            expect_val(SEL_EPC, 32'h0000_5000, "int_wins_epc");

    // eret together with mtc0 SR writing EXL=1: EXL ends clear
    step(); EXLClr = 1'b1; WE = 1'b1; Addr = 5'd12; WData = 32'h0000_FC03;
    step(); expect_rd(5'd12, 32'h0000_FC01, "eret_after_mtc0");

    // mtc0 EPC, no bypass in the write cycle
    step(); WE = 1'b1; Addr = 5'd14; WData = 32'hDEAD_BEEF;
            expect_val(SEL_RDATA, 32'h0000_5000, "epc_rdata_no_bypass");
            expect_val(SEL_EPC, 32'h0000_5000, "epc_out_no_bypass");
    step(); expect_val(SEL_EPC, 32'hDEAD_BEEF, "epc_written");

    // masking: only IM bit 0 enabled
    step(); WE = 1'b1; Addr = 5'd12; WData = 32'h0000_0401;
    step(); HWInt = 6'b000010;
            expect_rd(5'd12, 32'h0000_0401, "sr_im0");
            expect_val(SEL_REQ, 32'd0, "masked_int");
    step(); HWInt = 6'b000001; VPC = 32'h0000_6000;
            expect_val(SEL_REQ, 32'd1, "unmasked_int");
            reset = 1'b1;

    // reset overrides the pending Req
    step(); HWInt = 6'd0;
            expect_rd(5'd14, 32'h0, "reset_over_req_epc");
    step(); expect_rd(5'd12, 32'h0, "reset_over_req_sr");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
